// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants, IF/ID payload type and helpers for the instruction fetch stage.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] NOP_ENC          = 32'h0000_0000; // sll $0,$0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_HOLD   = 2'd3
  } pc_sel_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: reset > hold (stall) > squash > capture.
module if_id_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_ENC
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        squash,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  if_id_t q;
  if_id_t bubble;

  assign bubble = '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};

  always_ff @(posedge clk) begin
    if (reset)       q <= bubble;
    else if (hold)   q <= q;
    else if (squash) q <= bubble;
    else             q <= '{instr: instr_in, pc_plus4: pc_plus4_in, valid: 1'b1};
  end

  assign instr    = q.instr;
  assign pc_plus4 = q.pc_plus4;
  assign valid    = q.valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, next-PC select and IF/ID register.
// Optional stall/squash counters when FETCH_PERF_COUNT_EN is defined.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] instr_id,
  output logic [31:0] pc_plus4_id,
  output logic        valid_id
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] squash_cycles
`endif
);

  pc_sel_e     sel;
  logic [31:0] pc_inc;
  logic [31:0] pc_next;
  logic        redirect;

  assign pc_inc    = pc + PC_INC;
  assign imem_addr = pc;

  always_comb begin
    sel = SEL_SEQ;
    if (stall)             sel = SEL_HOLD;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
  end

  // Targets pass through unaligned; ID owns alignment checks.
  always_comb begin
    pc_next = pc_inc;
    case (sel)
      SEL_HOLD:   pc_next = pc;
      SEL_JUMP:   pc_next = jump_target;
      SEL_BRANCH: pc_next = branch_target;
      default:    pc_next = pc_inc;
    endcase
  end

  assign redirect = (sel == SEL_JUMP) || (sel == SEL_BRANCH);

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .hold       (stall),
    .squash     (redirect),
    .instr_in   (imem_data),
    .pc_plus4_in(pc_inc),
    .instr      (instr_id),
    .pc_plus4   (pc_plus4_id),
    .valid      (valid_id)
  );

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles  <= 32'd0;
      squash_cycles <= 32'd0;
    end else begin
      if (stall)    stall_cycles  <= sat_inc(stall_cycles);
      if (redirect) squash_cycles <= sat_inc(squash_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed, table-driven bench for instruction_fetch_stage; imem word at addr a is 8C08_0004 + a.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_data, pc, instr_id, pc_plus4_id;
  logic        valid_id;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] stall_cycles, squash_cycles;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'h8C08_0004 + imem_addr;

  instruction_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc           (pc),
    .instr_id     (instr_id),
    .pc_plus4_id  (pc_plus4_id),
    .valid_id     (valid_id)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .stall_cycles (stall_cycles),
    .squash_cycles(squash_cycles)
`endif
  );

  typedef struct {
    logic        rst, stl, br, jmp;
    logic [31:0] btgt, jtgt;
    logic [31:0] e_pc, e_instr, e_pp4;
    logic        e_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, stl, br, jmp, input logic [31:0] btgt, jtgt,
                     input logic [31:0] e_pc, e_instr, e_pp4, input logic e_vld);
    vec_t v;
    v = '{rst, stl, br, jmp, btgt, jtgt, e_pc, e_instr, e_pp4, e_vld};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, stl, br, jmp, input logic [31:0] btgt, jtgt);
    reset = rst; stall = stl; branch_taken = br; jump = jmp;
    branch_target = btgt; jump_target = jtgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;

    //  rst stl br jmp btgt        jtgt          pc            instr          pp4           vld
    add(1, 0, 0, 0, 32'h0,       32'h0,        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);
    add(0, 0, 0, 0, 32'h0,       32'h0,        32'h0000_0004, 32'h8C08_0004, 32'h0000_0004, 1);
    add(0, 0, 0, 0, 32'h0,       32'h0,        32'h0000_0008, 32'h8C08_0008, 32'h0000_0008, 1);
    add(0, 1, 0, 0, 32'h0,       32'h0,        32'h0000_0008, 32'h8C08_0008, 32'h0000_0008, 1);
    add(0, 1, 0, 0, 32'h0,       32'h0,        32'h0000_0008, 32'h8C08_0008, 32'h0000_0008, 1);
    add(0, 0, 0, 0, 32'h0,       32'h0,        32'h0000_000C, 32'h8C08_000C, 32'h0000_000C, 1);
    add(0, 0, 0, 0, 32'h0,       32'h0,        32'h0000_0010, 32'h8C08_0010, 32'h0000_0010, 1);
    add(0, 0, 1, 0, 32'h40,      32'h0,        32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0);
    add(0, 0, 0, 0, 32'h0,       32'h0,        32'h0000_0044, 32'h8C08_0044, 32'h0000_0044, 1);
    add(0, 1, 1, 0, 32'h100,     32'h0,        32'h0000_0044, 32'h8C08_0044, 32'h0000_0044, 1);
    add(0, 0, 1, 1, 32'h300,     32'h200,      32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 0);
    add(0, 0, 0, 0, 32'h0,       32'h0,        32'h0000_0204, 32'h8C08_0204, 32'h0000_0204, 1);
    add(1, 1, 0, 0, 32'h0,       32'h0,        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);
    add(0, 0, 0, 1, 32'h0,       32'hFFFF_FFFC,32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0);
    add(0, 0, 0, 0, 32'h0,       32'h0,        32'h0000_0000, 32'h8C08_0000, 32'h0000_0000, 1);
    add(0, 0, 0, 1, 32'h0,       32'h123,      32'h0000_0123, 32'h0000_0000, 32'h0000_0000, 0);
    add(0, 0, 0, 0, 32'h0,       32'h0,        32'h0000_0127, 32'h8C08_0127, 32'h0000_0127, 1);
    add(1, 0, 1, 1, 32'h80,      32'h90,       32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].jmp, vecs[i].btgt, vecs[i].jtgt);
      chk($sformatf("v%0d pc", i),          pc,                  vecs[i].e_pc);
      chk($sformatf("v%0d imem_addr", i),   imem_addr,           vecs[i].e_pc);
      chk($sformatf("v%0d instr_id", i),    instr_id,            vecs[i].e_instr);
      chk($sformatf("v%0d pc_plus4_id", i), pc_plus4_id,         vecs[i].e_pp4);
      chk($sformatf("v%0d valid_id", i),    {31'd0, valid_id},   {31'd0, vecs[i].e_vld});
    end

    // Long stall: five edges frozen, release resumes with the held word.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 1, 32'h500, 32'h600);
      chk($sformatf("long stall %0d pc", i),    pc,       32'h4);
      chk($sformatf("long stall %0d instr", i), instr_id, 32'h8C08_0004);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("stall release pc",    pc,          32'h8);
    chk("stall release instr", instr_id,    32'h8C08_0008);
    chk("stall release pp4",   pc_plus4_id, 32'h8);

`ifdef FETCH_PERF_COUNT_EN
    drive(1, 0, 0, 0, 0, 0);
    chk("perf reset stall",  stall_cycles,  32'd0);
    chk("perf reset squash", squash_cycles, 32'd0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 32'h40, 0);
    drive(0, 0, 1, 0, 32'h40, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("perf stall count",  stall_cycles,  32'd3);
    chk("perf squash count", squash_cycles, 32'd1);
    drive(1, 1, 0, 1, 0, 32'h80);
    chk("perf clear stall",  stall_cycles,  32'd0);
    chk("perf clear squash", squash_cycles, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
